days_lable_scan: RTL and testbench
==================================

// Module: days_lable_scan
// PURPOSE
// - Raster stage feeding days_lable_to_pix. Maps VGA pixel coordinates onto a horizontal strip of 7 day-label cells.
// - Tracks the position inside each cell with counters, issues cur_pos/pos_x/pos_y to the label ROM, and turns the returned pixel into RGB.
// - Highlights the current weekday. The day is latched once per frame.
// - Sits between the VGA timing generator and the calendar colour mux. Syncs are delayed to match the pixel latency.
// PARAMETERS
// ORIG_X   10   strip left edge, screen px
// ORIG_Y   20   strip top edge, screen px
// CELL_W   132  cell width, px; must be >= MAX_X+1 (label L_OFFSET=1)
// MAX_X    130  label glyph width, passed to days_lable_to_pix
// MAX_Y    30   label glyph height = strip height
// PIX_X_W  12   screen x width;  PIX_Y_W 12  screen y width
// COLOR_W  24   RGB width
// FG/BG/HL_FG/HL_BG  24'hFFFFFF/24'h000000/24'h000000/24'hFFC000  colours: normal fg/bg, highlighted fg/bg
// PORTS
// clk_i        in   1        pixel clock
// rst_i        in   1        synchronous reset, active-low
// pix_x_i      in   PIX_X_W  screen x, +1 per cycle while de_i
// pix_y_i      in   PIX_Y_W  screen y
// de_i         in   1        active video
// hs_i, vs_i   in   1        syncs (vs_i active-high frame pulse)
// today_i      in   3        current weekday, 0=MON..6=SUN
// today_vld_i  in   1        today_i valid
// rgb_o        out  COLOR_W  pixel colour
// de_o,hs_o,vs_o out 1       delayed de/hs/vs
// in_lable_o   out  1        rgb_o comes from the label strip
// BEHAVIOUR
// - Latency: input to rgb_o/de_o/hs_o/vs_o/in_lable_o = 3 cycles, fixed.
//   - S1: coordinate registers.
//   - S2: ROM access inside days_lable_to_pix.
//   - S3: colour register.
// - Reset (rst_i==0 at an edge): all outputs 0, all pipeline valid/sync bits 0, today_q=7 (no highlight), counters 0.
// - S1 region: hit = de_i && pix_y_i in [ORIG_Y, ORIG_Y+MAX_Y) && pix_x_i in [ORIG_X, ORIG_X+7*CELL_W).
// - S1 counters:
//   - Load when hit and pix_x_i==ORIG_X: cx=0, col=0.
//   - Otherwise, on hit with active_q=1: cx++. When cx==CELL_W-1, cx wraps to 0 and col++.
//   - active_q is set by a load and cleared by !hit.
//   - A line entered mid-strip (e.g. after reset) stays blank until the next load. There is no division on x.
// - pos_y = pix_y_i - ORIG_Y, registered in S1, width PIX_Y_W.
// - cur_pos = POS_LUT[col] from the package: MON..SUN lable codes of cal_draw_def.
// - vld_s1 = hit && (load || active_q).
// - today_q: on vs_i rising edge (vs_i && !vs_q) with today_vld_i, today_q <= today_i.
//   - today_i > 6 loads 7 (no highlight).
//   - A new value never takes effect mid-frame.
// - S3 colour:
//   - !vld_s2: rgb=0, in_lable=0.
//   - vld_s2 && col_s2==today_q: rgb = pix ? HL_FG : HL_BG.
//   - vld_s2, other col: rgb = pix ? FG : BG.
//   - de_s2==0 forces rgb=0.
// - Boundaries:
//   - Last px of cell 6 is followed by in_lable_o=0.
//   - cx wrap and col++ happen in the same cycle.
//   - vs edge coinciding with hit: latch and scan proceed independently.
//   - Reset mid-line: outputs 0 on the next cycle; scan resumes at the next ORIG_X.
// - Gap px inside a cell (cx>MAX_X) come out as BG/HL_BG, because the submodule blanks them.
// STRUCTURE
// - Package cal_scan_pkg:
//   - POS_LUT[7] (col to CAL_POS code).
//   - NO_DAY=3'd7.
//   - rgb_t typedef.
//   - Default colour constants.
// - One sub-module: days_lable_to_pix.
//   - Driven with cur_pos_i=cur_pos, pos_x_i=cx, pos_y_i=pos_y.
//   - Its 1-cycle q defines S2.
// - Sync/de/valid/col delay is a plain shift register in this module.
// TESTING
// - Reset: hold rst_i=0 for 5 cycles with de_i=1 -> rgb_o=0, de_o=0, in_lable_o=0 throughout; today_q=7.
// - Mapping: y=25, x=10..933 -> at x=279 (col 2, cx=5) cur_pos=WED, pos_x=5, pos_y=5; in_lable_o=1 exactly 3 cycles after x=10 and 0 after x=933.
// - Highlight: vs pulse with today_i=2, today_vld_i=1 -> WED cell uses HL_FG/HL_BG, other cells FG/BG; change today_i mid-frame -> no change until next vs.
// - Mid-line entry: release reset while x=500 on row y=30 -> in_lable_o=0 for the rest of row 30; row 31 fully drawn.
// - Cell wrap: x=141 -> cx=131, col 0; x=142 -> cx=0, col 1, cur_pos=TUE; gap px (cx=131) -> rgb_o=BG.
// - Outside strip: y=19 and y=50 with x=100 -> in_lable_o=0, rgb_o=0; de_o/hs_o/vs_o equal the inputs delayed by 3.

Source files
------------

// File: rtl/days_lable_scan_pkg.sv
// Shared constants and types for the day-label strip scanner.
// Screen geometry, colours and the column to label-code table.
package cal_scan_pkg;

    localparam int PIX_X_W  = 12;
    localparam int PIX_Y_W  = 12;
    localparam int COLOR_W  = 24;
    localparam int ORIG_X   = 10;
    localparam int ORIG_Y   = 20;
    localparam int CELL_W   = 132;
    localparam int MAX_X    = 130;
    localparam int MAX_Y    = 30;
    localparam int N_CELL   = 7;
    localparam int CX_W     = 8;
    localparam int L_OFFSET = 1;

    typedef logic [COLOR_W-1:0] rgb_t;

    localparam rgb_t FG    = 24'hFFFFFF;
    localparam rgb_t BG    = 24'h000000;
    localparam rgb_t HL_FG = 24'h000000;
    localparam rgb_t HL_BG = 24'hFFC000;

    localparam logic [2:0] NO_DAY = 3'd7;

    typedef enum logic [4:0] {
        POS_NONE = 5'd0,
        POS_MON  = 5'd16,
        POS_TUE  = 5'd17,
        POS_WED  = 5'd18,
        POS_THU  = 5'd19,
        POS_FRI  = 5'd20,
        POS_SAT  = 5'd21,
        POS_SUN  = 5'd22
    } cal_pos_t;

    localparam cal_pos_t POS_LUT [N_CELL] = '{
        POS_MON, POS_TUE, POS_WED, POS_THU,
        POS_FRI, POS_SAT, POS_SUN
    };

    function automatic cal_pos_t pos_of(input logic [2:0] c);
        if (c < 3'(N_CELL))
            return POS_LUT[c];
        return POS_NONE;
    endfunction

endpackage

// File: rtl/days_lable_scan_if.sv
// Raster-in / colour-out bundle of the day-label scanner.
// slave is the scanner side, master the timing/mux side.
interface days_lable_scan_if;
    import cal_scan_pkg::*;

    logic [PIX_X_W-1:0] pix_x_i;
    logic [PIX_Y_W-1:0] pix_y_i;
    logic               de_i;
    logic               hs_i;
    logic               vs_i;
    logic [2:0]         today_i;
    logic               today_vld_i;
    rgb_t               rgb_o;
    logic               de_o;
    logic               hs_o;
    logic               vs_o;
    logic               in_lable_o;

    modport slave (
        input  pix_x_i, pix_y_i, de_i, hs_i, vs_i,
        input  today_i, today_vld_i,
        output rgb_o, de_o, hs_o, vs_o, in_lable_o
    );

    modport master (
        output pix_x_i, pix_y_i, de_i, hs_i, vs_i,
        output today_i, today_vld_i,
        input  rgb_o, de_o, hs_o, vs_o, in_lable_o
    );

endinterface

// File: rtl/days_lable_to_pix.sv
// Label glyph source: one registered pixel per (code, x, y).
// Columns outside [L_OFFSET, MAX_X] and rows >= MAX_Y are blank.
module days_lable_to_pix
    import cal_scan_pkg::cal_pos_t;
    import cal_scan_pkg::CX_W;
    import cal_scan_pkg::PIX_Y_W;
    import cal_scan_pkg::L_OFFSET;
#(
    parameter int MAX_X = 130,
    parameter int MAX_Y = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  cal_pos_t           cur_pos_i,
    input  logic [CX_W-1:0]    pos_x_i,
    input  logic [PIX_Y_W-1:0] pos_y_i,
    output logic               pix_o
);

    logic in_box;
    logic bit_on;

    assign in_box = (pos_x_i >= CX_W'(L_OFFSET))
                 && (pos_x_i <= CX_W'(MAX_X))
                 && (pos_y_i <  PIX_Y_W'(MAX_Y));

    // Procedural glyph: stripes keyed by code parity
    assign bit_on = pos_x_i[3] ^ pos_y_i[2] ^ cur_pos_i[0];

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            pix_o <= 1'b0;
        else
            pix_o <= in_box && bit_on;
    end

endmodule

// File: rtl/days_lable_scan.sv
// Raster stage for the 7-cell weekday label strip.
// S1 coordinates, S2 glyph lookup, S3 colour; 3-cycle latency.
module days_lable_scan
    import cal_scan_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    days_lable_scan_if.slave bus
);

    localparam int X_END = ORIG_X + N_CELL * CELL_W;
    localparam int Y_END = ORIG_Y + MAX_Y;

    localparam logic [PIX_X_W-1:0] X_LO = PIX_X_W'(ORIG_X);
    localparam logic [PIX_X_W-1:0] X_HI = PIX_X_W'(X_END);
    localparam logic [PIX_Y_W-1:0] Y_LO = PIX_Y_W'(ORIG_Y);
    localparam logic [PIX_Y_W-1:0] Y_HI = PIX_Y_W'(Y_END);
    localparam logic [CX_W-1:0]    CX_LAST = CX_W'(CELL_W - 1);

    logic hit;
    logic load;

    logic [CX_W-1:0]    cx;
    logic [2:0]         col;
    logic               active_q;
    logic [PIX_Y_W-1:0] pos_y;
    logic               vld_s1, de_s1, hs_s1, vs_s1;
    cal_pos_t           cur_pos;

    logic               pix_s2;
    logic               vld_s2, de_s2, hs_s2, vs_s2;
    logic [2:0]         col_s2;

    logic [2:0]         today_q;
    logic               vs_q;

    rgb_t               rgb_q;
    logic               de_q, hs_q, vs_oq, in_lable_q;

    assign hit = bus.de_i
              && (bus.pix_y_i >= Y_LO) && (bus.pix_y_i < Y_HI)
              && (bus.pix_x_i >= X_LO) && (bus.pix_x_i < X_HI);
    assign load = hit && (bus.pix_x_i == X_LO);

    // Cell position is tracked by counting, never by dividing x
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cx       <= '0;
            col      <= '0;
            active_q <= 1'b0;
            pos_y    <= '0;
            vld_s1   <= 1'b0;
            de_s1    <= 1'b0;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
        end else begin
            vld_s1 <= hit && (load || active_q);
            de_s1  <= bus.de_i;
            hs_s1  <= bus.hs_i;
            vs_s1  <= bus.vs_i;
            pos_y  <= bus.pix_y_i - Y_LO;
            if (load) begin
                cx       <= '0;
                col      <= '0;
                active_q <= 1'b1;
            end else if (!hit) begin
                active_q <= 1'b0;
            end else if (active_q) begin
                if (cx == CX_LAST) begin
                    cx  <= '0;
                    col <= col + 3'd1;
                end else begin
                    cx <= cx + CX_W'(1);
                end
            end
        end
    end

    assign cur_pos = pos_of(col);

    days_lable_to_pix #(
        .MAX_X (MAX_X),
        .MAX_Y (MAX_Y)
    ) u_pix (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cur_pos_i (cur_pos),
        .pos_x_i   (cx),
        .pos_y_i   (pos_y),
        .pix_o     (pix_s2)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_s2 <= 1'b0;
            col_s2 <= '0;
            de_s2  <= 1'b0;
            hs_s2  <= 1'b0;
            vs_s2  <= 1'b0;
        end else begin
            vld_s2 <= vld_s1;
            col_s2 <= col;
            de_s2  <= de_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    // Weekday only changes on a frame start
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            today_q <= NO_DAY;
            vs_q    <= 1'b0;
        end else begin
            vs_q <= bus.vs_i;
            if (bus.vs_i && !vs_q && bus.today_vld_i)
                today_q <= (bus.today_i > 3'd6) ? NO_DAY : bus.today_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rgb_q      <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_oq      <= 1'b0;
            in_lable_q <= 1'b0;
        end else begin
            de_q       <= de_s2;
            hs_q       <= hs_s2;
            vs_oq      <= vs_s2;
            in_lable_q <= vld_s2 && de_s2;
            if (!vld_s2 || !de_s2)
                rgb_q <= '0;
            else if (col_s2 == today_q)
                rgb_q <= pix_s2 ? HL_FG : HL_BG;
            else
                rgb_q <= pix_s2 ? FG : BG;
        end
    end

    assign bus.rgb_o      = rgb_q;
    assign bus.de_o       = de_q;
    assign bus.hs_o       = hs_q;
    assign bus.vs_o       = vs_oq;
    assign bus.in_lable_o = in_lable_q;

endmodule

// File: tb/tb_days_lable_scan.sv
// Directed bench for days_lable_scan with a 3-deep expected-value pipe.
// Expected colours come from an independent x/y based reference.
module tb_days_lable_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    days_lable_scan_if bus ();

    days_lable_scan dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       vld;
        logic [2:0] col;
        logic       pix;
        logic       de;
        logic       hs;
        logic       vs;
        int         x;
        int         y;
    } exp_t;

    exp_t       q[$];
    logic       m_active = 1'b0;
    logic       m_vsq    = 1'b0;
    logic [2:0] m_today  = 3'd7;
    logic [2:0] m_today1 = 3'd7;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t zero_e();
        exp_t e;
        e.vld = 1'b0; e.col = 3'd0; e.pix = 1'b0;
        e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
        e.x = -1; e.y = -1;
        return e;
    endfunction

    task automatic step(input logic r, input int x, input int y,
                        input logic de, input logic hs, input logic vs,
                        input logic [2:0] td, input logic tv);
        exp_t        e;
        logic        hit;
        int          cx, cl, py;
        logic [23:0] rgb;
        logic [31:0] exp_v, got_v;
        rst             = r;
        bus.pix_x_i     = 12'(x);
        bus.pix_y_i     = 12'(y);
        bus.de_i        = de;
        bus.hs_i        = hs;
        bus.vs_i        = vs;
        bus.today_i     = td;
        bus.today_vld_i = tv;
        hit = de && y >= 20 && y < 50 && x >= 10 && x < 934;
        cx  = (x - 10) % 132;
        cl  = (x - 10) / 132;
        py  = y - 20;
        e   = zero_e();
        if (!r) begin
            q.delete();
            q.push_back(e); q.push_back(e); q.push_back(e);
            m_active = 1'b0; m_vsq = 1'b0;
            m_today  = 3'd7; m_today1 = 3'd7;
        end else begin
            e.vld = hit && (x == 10 || m_active);
            e.col = cl[2:0];
            e.de  = de; e.hs = hs; e.vs = vs;
            e.x   = x;  e.y  = y;
            e.pix = cx >= 1 && cx <= 130 &&
                    ((((cx >> 3) & 1) ^ ((py >> 2) & 1) ^ (cl & 1)) != 0);
            if (hit && x == 10) m_active = 1'b1;
            else if (!hit)      m_active = 1'b0;
            m_today1 = m_today;
            if (vs && !m_vsq && tv) m_today = (td > 3'd6) ? 3'd7 : td;
            m_vsq = vs;
            q.push_back(e);
        end
        @(negedge clk);
        e = q.pop_front();
        if (!e.vld || !e.de)           rgb = 24'h000000;
        else if (e.col == m_today1)    rgb = e.pix ? 24'h000000 : 24'hFFC000;
        else                           rgb = e.pix ? 24'hFFFFFF : 24'h000000;
        exp_v = {4'b0, e.vld && e.de, e.de, e.hs, e.vs, rgb};
        got_v = {4'b0, bus.in_lable_o, bus.de_o, bus.hs_o, bus.vs_o,
                 bus.rgb_o};
        check($sformatf("pipe y%0d x%0d", e.y, e.x), got_v, exp_v);
    endtask

    task automatic row(input int y, input int vs_x, input int rst_x,
                       input logic [2:0] td, input logic tv);
        for (int x = 0; x < 950; x++) begin
            step(!(x < rst_x), x, y, 1'b1, 1'b0, x >= vs_x, td, tv);
            if (y == 25 && x == 279) begin
                check("map cur_pos", 32'(dut.cur_pos), 32'd18);
                check("map pos_x", 32'(dut.cx), 32'd5);
                check("map pos_y", 32'(dut.pos_y), 32'd5);
                check("map col", 32'(dut.col), 32'd2);
            end
            if (y == 25 && x == 141) begin
                check("wrap cx131", 32'(dut.cx), 32'd131);
                check("wrap col0", 32'(dut.col), 32'd0);
            end
            if (y == 25 && x == 142) begin
                check("wrap cx0", 32'(dut.cx), 32'd0);
                check("wrap col1", 32'(dut.col), 32'd1);
                check("wrap tue", 32'(dut.cur_pos), 32'd17);
            end
        end
        for (int i = 0; i < 10; i++)
            step(1'b1, 0, y, 1'b0, 1'b1, 1'b0, td, tv);
    endtask

    task automatic vsync(input logic [2:0] td, input logic tv);
        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, td, tv);
        for (int i = 0; i < 2; i++)
            step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, td, tv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_x_i = '0; bus.pix_y_i = '0;
        bus.de_i = 1'b1; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
        bus.today_i = 3'd0; bus.today_vld_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            step(1'b0, 100 + i, 25, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        check("rst today_q", 32'(dut.today_q), 32'd7);

        row(19, 4096, 0, 3'd0, 1'b0);
        row(25, 4096, 0, 3'd0, 1'b0);

        vsync(3'd2, 1'b1);
        check("vs today_q=2", 32'(dut.today_q), 32'd2);
        row(26, 4096, 0, 3'd2, 1'b1);
        row(27, 4096, 0, 3'd4, 1'b1);
        check("midframe hold", 32'(dut.today_q), 32'd2);
        vsync(3'd4, 1'b1);
        check("vs today_q=4", 32'(dut.today_q), 32'd4);
        row(28, 4096, 0, 3'd4, 1'b1);

        row(29, 300, 0, 3'd5, 1'b1);
        check("vs in hit", 32'(dut.today_q), 32'd5);
        vsync(3'd7, 1'b1);
        check("today>6", 32'(dut.today_q), 32'd7);
        vsync(3'd1, 1'b0);
        check("vld low hold", 32'(dut.today_q), 32'd7);
        vsync(3'd1, 1'b1);
        check("vs today_q=1", 32'(dut.today_q), 32'd1);

        row(30, 4096, 500, 3'd1, 1'b0);
        check("midrst today", 32'(dut.today_q), 32'd7);
        row(31, 4096, 0, 3'd1, 1'b0);
        row(50, 4096, 0, 3'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
